// File: rtl/seg7_pkg.sv
// Shared constants for the MM:SS seven-segment scan driver: active-low
// segment patterns ({g,f,e,d,c,b,a}), the digit-index type and the slot map.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digit slot index; slot 0 is the rightmost digit.
    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t IDX_SEC_ONES = 2'd0;
    localparam digit_idx_t IDX_SEC_TENS = 2'd1;
    localparam digit_idx_t IDX_MIN_ONES = 2'd2;
    localparam digit_idx_t IDX_MIN_TENS = 2'd3;

endpackage

// File: rtl/seg7_time_scan_decode.sv
// 4-bit value to active-low seven-segment pattern; anything above 9 is a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);

    // Pure lookup; out-of-range tens/ones inputs fall into the dash default.
    always_comb begin
        seg = SEG_DASH;
        case (val)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_time_scan.sv
// Multiplexed 4-digit MM:SS display driver with per-slot anti-ghost guard,
// tear-free frame snapshot and registered active-low outputs.
// Build option: COLON_BLINK_EN makes the colon toggle on every ENABLE tick;
// without it the colon is steadily lit and ENABLE is unused.
module seg7_time_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       BLANK,
    input  logic [3:0] SEC_ONES,
    input  logic [2:0] SEC_TENS,
    input  logic [3:0] MIN_ONES,
    input  logic [2:0] MIN_TENS,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       DP
);

    localparam int              PC_W     = $clog2(SCAN_DIV);
    localparam logic [PC_W-1:0] PC_LAST  = PC_W'(SCAN_DIV - 1);
    localparam logic [PC_W-1:0] GUARD_PC = PC_W'(GUARD);

    logic [PC_W-1:0]  pc;
    digit_idx_t       idx;
    logic [3:0][3:0]  snap;
    logic             col;

    logic             slot_end;
    logic             frame_end;
    logic             an_off;
    logic [3:0]       cur_digit;
    logic [6:0]       dec_seg;

    assign slot_end  = (pc == PC_LAST);
    assign frame_end = slot_end && (idx == IDX_MIN_TENS);
    assign an_off    = BLANK || (pc < GUARD_PC);
    assign cur_digit = snap[idx];

    seg7_decode u_decode (
        .val (cur_digit),
        .seg (dec_seg)
    );

    // Prescaler and digit index: idx steps once per SCAN_DIV cycles.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc  <= '0;
            idx <= IDX_SEC_ONES;
        end else if (slot_end) begin
            pc  <= '0;
            idx <= idx + 2'd1;
        end else begin
            pc  <= pc + 1'b1;
        end
    end

    // Snapshot all digits at the frame boundary so a frame never mixes old and new time.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            snap <= '0;
        end else if (frame_end) begin
            snap[IDX_SEC_ONES] <= SEC_ONES;
            snap[IDX_SEC_TENS] <= {1'b0, SEC_TENS};
            snap[IDX_MIN_ONES] <= MIN_ONES;
            snap[IDX_MIN_TENS] <= {1'b0, MIN_TENS};
        end
    end

`ifdef COLON_BLINK_EN
    // Colon toggles on each 1 s tick, independent of the snapshot edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)       col <= 1'b0;
        else if (ENABLE) col <= ~col;
    end
`else
    logic unused_enable;
    assign unused_enable = ENABLE;

    // Steady colon: leaves its reset value on the first edge and stays lit.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) col <= 1'b0;
        else       col <= 1'b1;
    end
`endif

    // Registered drives; segments update even in the guard window so they settle early.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            AN  <= 4'hF;
            SEG <= SEG_BLANK;
            DP  <= 1'b1;
        end else begin
            AN  <= an_off ? 4'hF : ~(4'b0001 << idx);
            SEG <= dec_seg;
            DP  <= ~(!an_off && (idx == IDX_MIN_ONES) && col);
        end
    end

endmodule

// File: tb/tb_seg7_time_scan.sv
// Self-checking bench for seg7_time_scan (SCAN_DIV=8, GUARD=2): directed
// scenarios followed by random digits/BLANK/ENABLE, all checked each cycle
// against a cycle-count based reference model.
module tb_seg7_time_scan;

    localparam int SD    = 8;
    localparam int G     = 2;
    localparam int FRAME = 4 * SD;

    localparam logic [6:0] TBL [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ENABLE;
    logic       BLANK;
    logic [3:0] SEC_ONES;
    logic [2:0] SEC_TENS;
    logic [3:0] MIN_ONES;
    logic [2:0] MIN_TENS;
    logic [3:0] AN;
    logic [6:0] SEG;
    logic       DP;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: edges since reset release, digits shown this frame, colon.
    int         c;
    int         shown [4];
    logic       col_m;

    seg7_time_scan #(.SCAN_DIV(SD), .GUARD(G)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENABLE   (ENABLE),
        .BLANK    (BLANK),
        .SEC_ONES (SEC_ONES),
        .SEC_TENS (SEC_TENS),
        .MIN_ONES (MIN_ONES),
        .MIN_TENS (MIN_TENS),
        .AN       (AN),
        .SEG      (SEG),
        .DP       (DP)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] ref_seg(input int v);
        if (v > 9) return 7'h3F;
        return TBL[v];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, c);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_an"},  AN,  4'hF);
        chk({tag, "_seg"}, SEG, 7'h7F);
        chk({tag, "_dp"},  DP,  1'b1);
    endtask

    task automatic model_reset();
        c     = 0;
        col_m = 1'b0;
        for (int i = 0; i < 4; i++) shown[i] = 0;
    endtask

    // One clock edge, checked against the model's view of the cycle before it.
    task automatic tick();
        int         pc, idx;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, en, last;
        int         nxt [4];
        pc    = c % SD;
        idx   = (c / SD) % 4;
        e_an  = (BLANK || pc < G) ? 4'hF : ~(4'b0001 << idx);
        e_seg = ref_seg(shown[idx]);
        e_dp  = !(e_an != 4'hF && idx == 2 && col_m);
        last  = (c % FRAME) == FRAME - 1;
        nxt[0] = int'(SEC_ONES); nxt[1] = int'(SEC_TENS);
        nxt[2] = int'(MIN_ONES); nxt[3] = int'(MIN_TENS);
        en = ENABLE;
        @(posedge CLK);
        #1;
        chk("an",  AN,  e_an);
        chk("seg", SEG, e_seg);
        chk("dp",  DP,  e_dp);
        if (last) for (int i = 0; i < 4; i++) shown[i] = nxt[i];
`ifdef COLON_BLINK_EN
        if (en) col_m = ~col_m;
`else
        col_m = 1'b1;
`endif
        c++;
    endtask

    task automatic set_time(input int mt, input int mo, input int st, input int so);
        MIN_TENS = 3'(mt); MIN_ONES = 4'(mo);
        SEC_TENS = 3'(st); SEC_ONES = 4'(so);
    endtask

    initial begin
        logic prev_en;
        int   blank_left;

        RESET = 1'b1; ENABLE = 1'b0; BLANK = 1'b0;
        set_time(0, 0, 0, 0);
        model_reset();
        #1;
        chk_reset("por");
        @(posedge CLK); #1;
        chk_reset("por_edge");
        RESET = 1'b0;

        // First frame shows the zeroed snapshot, then 12:34 from the second frame.
        set_time(1, 2, 3, 4);
        for (int i = 0; i < 2 * FRAME; i++) tick();

        // Tear-free: SEC_ONES 4->5 inside the idx1 slot of the current frame.
        while ((c / SD) % 4 != 1) tick();
        tick(); tick();
        SEC_ONES = 4'd5;
        for (int i = 0; i < 2 * FRAME; i++) tick();

        // Out-of-range digits render as dashes.
        set_time(7, 12, 6, 15);
        for (int i = 0; i < 2 * FRAME; i++) tick();

        // Asynchronous reset mid-slot, without a clock edge.
        set_time(5, 9, 4, 8);
        for (int i = 0; i < 13; i++) tick();
        #2;
        RESET = 1'b1;
        #1;
        chk_reset("async");
        @(posedge CLK); #1;
        chk_reset("async_edge");
        RESET = 1'b0;
        model_reset();
        for (int i = 0; i < 2 * FRAME; i++) tick();

        // BLANK held for 10 cycles mid-frame; scanning must keep advancing.
        for (int i = 0; i < 5; i++) tick();
        BLANK = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        BLANK = 1'b0;
        for (int i = 0; i < FRAME; i++) tick();

        // ENABLE pulses on and off the snapshot edge.
        while ((c % FRAME) != FRAME - 1) tick();
        ENABLE = 1'b1; tick(); ENABLE = 1'b0;
        for (int i = 0; i < FRAME; i++) tick();
        ENABLE = 1'b1; tick(); ENABLE = 1'b0;
        for (int i = 0; i < FRAME; i++) tick();

        // Random digits, BLANK windows and one-wide ENABLE pulses.
        prev_en    = 1'b0;
        blank_left = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0: SEC_ONES = 4'($urandom_range(0, 15));
                    1: SEC_TENS = 3'($urandom_range(0, 7));
                    2: MIN_ONES = 4'($urandom_range(0, 15));
                    default: MIN_TENS = 3'($urandom_range(0, 7));
                endcase
            end
            if (blank_left > 0) begin
                blank_left--;
                BLANK = (blank_left != 0);
            end else if ($urandom_range(0, 39) == 0) begin
                blank_left = $urandom_range(1, 12);
                BLANK      = 1'b1;
            end
            ENABLE  = !prev_en && ($urandom_range(0, 5) == 0);
            prev_en = ENABLE;
            tick();
        end
        ENABLE = 1'b0;
        BLANK  = 1'b0;
        for (int i = 0; i < FRAME; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
